// File: rtl/fighter_sprite_anim.sv
// fighter_sprite_anim: animated sprite-sheet renderer with 3-cycle pixel latency; define SPRITE_FLIP_EN for horizontal mirroring
module fighter_sprite_anim #(
  parameter int SPRITE_W        = 105,
  parameter int SPRITE_H        = 180,
  parameter int FRAMES          = 4,
  parameter int ADDR_W          = 17,
  parameter int IDX_W           = 5,
  parameter int TRANSPARENT_IDX = 0,
  parameter int HOLD            = 4,
  localparam int FW             = $clog2(FRAMES)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        PosX,
  input  logic [9:0]        PosY,
  input  logic              blank,
  input  logic              facing_left,
  input  logic              frame_tick,
  input  logic              anim_start,
  input  logic [FW-1:0]     anim_first,
  input  logic [FW:0]       anim_count,
  input  logic              anim_loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_on,
  output logic              anim_done,
  output logic [FW-1:0]     frame_idx
);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam logic [31:0] FRAME_SZ = 32'(SPRITE_W * SPRITE_H);
  localparam logic [31:0] ROW_SZ   = 32'(SPRITE_W);
  typedef enum logic {S_IDLE, S_PLAY} state_t;
  state_t            r_state;
  logic [HW-1:0]     r_hold_cnt;
  logic [FW-1:0]     r_frame_idx, r_first;
  logic [FW:0]       r_count, r_pos;
  logic              r_loop, r_anim_done;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_hit1, r_blank1, r_hit2, r_blank2, r_sprite_on;
  logic [3:0]        r_red, r_green, r_blue;
  logic [10:0]       w_dx, w_dy, w_px, w_py;
  logic              w_hit, w_last, w_opaque;
  logic [9:0]        w_dcol, w_col, w_row;
  logic [FW-1:0]     w_next_frame;
  logic [ADDR_W-1:0] w_addr;
  assign w_dx   = {1'b0, DrawX};
  assign w_dy   = {1'b0, DrawY};
  assign w_px   = {1'b0, PosX};
  assign w_py   = {1'b0, PosY};
  assign w_hit  = (w_dx >= w_px) && (w_dx < w_px + 11'(SPRITE_W)) &&
                  (w_dy >= w_py) && (w_dy < w_py + 11'(SPRITE_H));
  assign w_dcol = DrawX - PosX;
  assign w_row  = DrawY - PosY;
`ifdef SPRITE_FLIP_EN
  assign w_col  = facing_left ? 10'(SPRITE_W - 1) - w_dcol : w_dcol;
`else
  logic w_unused_facing;
  assign w_unused_facing = facing_left;
  assign w_col  = w_dcol;
`endif
  assign w_addr = w_hit ? ADDR_W'(32'(r_frame_idx) * FRAME_SZ + 32'(w_row) * ROW_SZ + 32'(w_col)) : '0;
  assign w_opaque = r_hit2 && r_blank2 && (rom_q != IDX_W'(TRANSPARENT_IDX));
  // r_pos counts frames played, so wrap past FRAMES-1 never confuses the end test
  assign w_last       = r_pos == r_count - 1'b1;
  assign w_next_frame = (r_frame_idx == FW'(FRAMES - 1)) ? '0 : r_frame_idx + 1'b1;
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= '0;
      r_frame_idx <= '0;
      r_first     <= '0;
      r_count     <= '0;
      r_pos       <= '0;
      r_loop      <= 1'b0;
      r_anim_done <= 1'b0;
    end else begin
      r_anim_done <= 1'b0;
      if (anim_start) begin
        r_first     <= anim_first;
        r_count     <= (anim_count == '0) ? (FW+1)'(1) : anim_count;
        r_loop      <= anim_loop;
        r_frame_idx <= anim_first;
        r_hold_cnt  <= '0;
        r_pos       <= '0;
        r_state     <= S_PLAY;
      end else if (r_state == S_PLAY && frame_tick) begin
        if (r_hold_cnt != HW'(HOLD - 1)) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end else begin
          r_hold_cnt <= '0;
          if (!w_last) begin
            r_frame_idx <= w_next_frame;
            r_pos       <= r_pos + 1'b1;
          end else if (r_loop) begin
            r_frame_idx <= r_first;
            r_pos       <= '0;
          end else begin
            r_anim_done <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
      end
    end
  end
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_addr  <= '0;
      r_hit1      <= 1'b0;
      r_blank1    <= 1'b0;
      r_hit2      <= 1'b0;
      r_blank2    <= 1'b0;
      r_sprite_on <= 1'b0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
    end else begin
      r_rom_addr  <= w_addr;
      r_hit1      <= w_hit;
      r_blank1    <= blank;
      r_hit2      <= r_hit1;
      r_blank2    <= r_blank1;
      r_sprite_on <= w_opaque;
      r_red       <= w_opaque ? pal_red : 4'h0;
      r_green     <= w_opaque ? pal_green : 4'h0;
      r_blue      <= w_opaque ? pal_blue : 4'h0;
    end
  end
  assign rom_addr  = r_rom_addr;
  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;
  assign sprite_on = r_sprite_on;
  assign anim_done = r_anim_done;
  assign frame_idx = r_frame_idx;
endmodule

// File: tb/tb_fighter_sprite_anim.sv
// tb_fighter_sprite_anim: directed checks of addressing, pixel pipeline and animation sequencer
module tb_fighter_sprite_anim;
  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, PosX = '0, PosY = '0;
  logic        blank = 1'b0, facing_left = 1'b0, frame_tick = 1'b0, anim_start = 1'b0, anim_loop = 1'b0;
  logic [1:0]  anim_first = '0;
  logic [2:0]  anim_count = '0;
  logic [16:0] rom_addr;
  logic [4:0]  rom_q = '0, tb_idx = '0;
  logic [3:0]  pal_red, pal_green, pal_blue, red, green, blue;
  logic        sprite_on, anim_done;
  logic [1:0]  frame_idx;
  int          n_checks = 0, n_fail = 0;

  assign pal_red = 4'hA;
  assign pal_green = 4'h5;
  assign pal_blue = 4'hF;
  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) rom_q <= tb_idx;

  fighter_sprite_anim dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
    .blank(blank), .facing_left(facing_left), .frame_tick(frame_tick), .anim_start(anim_start),
    .anim_first(anim_first), .anim_count(anim_count), .anim_loop(anim_loop), .rom_addr(rom_addr),
    .rom_q(rom_q), .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue), .red(red),
    .green(green), .blue(blue), .sprite_on(sprite_on), .anim_done(anim_done), .frame_idx(frame_idx)
  );

  task step;
    @(posedge vga_clk);
    #1;
  endtask

  task tick;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task start(input logic [1:0] f, input logic [2:0] c, input logic l, input logic t);
    anim_first = f; anim_count = c; anim_loop = l; anim_start = 1'b1; frame_tick = t;
    step();
    anim_start = 1'b0; frame_tick = 1'b0;
  endtask

  task test_reset;
    step(); step();
    n_checks++;
    if ({rom_addr, red, green, blue, sprite_on, anim_done, frame_idx} !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h required 0", {rom_addr, red, green, blue, sprite_on, anim_done, frame_idx});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_address;
    logic [9:0]  px[8]  = '{100, 100, 100, 100, 100, 100, 1000, 1000};
    logic [9:0]  dx[8]  = '{100, 204, 205, 203, 203, 99, 1023, 5};
    logic [9:0]  dy[8]  = '{50, 51, 51, 229, 230, 50, 50, 50};
    logic [16:0] exp[8] = '{0, 209, 0, 18898, 0, 0, 23, 0};
    PosY = 50;
    for (int i = 0; i < 8; i++) begin
      PosX = px[i]; DrawX = dx[i]; DrawY = dy[i];
      step();
      n_checks++;
      if (rom_addr !== exp[i]) begin
        n_fail++; $display("FAIL address_%0d: got %0d required %0d", i, rom_addr, exp[i]);
      end
    end
  endtask

  task automatic pixel(input logic [4:0] idx, input logic b, input logic exp_on, input string name);
    PosX = 100; PosY = 50; DrawX = 204; DrawY = 51; tb_idx = idx; blank = b;
    step();
    DrawX = 0; blank = 1'b1;
    n_checks++;
    if (sprite_on !== 1'b0) begin n_fail++; $display("FAIL %s_lat1: got %b required 0", name, sprite_on); end
    step();
    n_checks++;
    if (sprite_on !== 1'b0) begin n_fail++; $display("FAIL %s_lat2: got %b required 0", name, sprite_on); end
    step();
    n_checks++;
    if ({sprite_on, red, green, blue} !== (exp_on ? 13'h1A5F : 13'h0)) begin
      n_fail++; $display("FAIL %s_lat3: got %h required %h", name, {sprite_on, red, green, blue}, exp_on ? 13'h1A5F : 13'h0);
    end
    step();
    n_checks++;
    if ({sprite_on, red, green, blue} !== 13'h0) begin
      n_fail++; $display("FAIL %s_after: got %h required 0", name, {sprite_on, red, green, blue});
    end
  endtask

  task test_pixel;
    pixel(5'd3, 1'b1, 1'b1, "opaque");
    pixel(5'd0, 1'b1, 1'b0, "transparent");
    pixel(5'd3, 1'b0, 1'b0, "blanked");
  endtask

  task automatic test_loop;
    logic [1:0] exp[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
    start(2'd1, 3'd2, 1'b1, 1'b0);
    PosX = 100; PosY = 50; DrawX = 100; DrawY = 50;
    step();
    n_checks++;
    if (rom_addr !== 17'd18900) begin n_fail++; $display("FAIL frame1_base: got %0d required 18900", rom_addr); end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (frame_idx !== exp[k]) begin n_fail++; $display("FAIL loop_seq_%0d: got %0d required %0d", k, frame_idx, exp[k]); end
      tick();
    end
  endtask

  task test_oneshot;
    start(2'd0, 3'd3, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++;
      if (anim_done !== (k == 12)) begin n_fail++; $display("FAIL oneshot_done_%0d: got %b required %b", k, anim_done, k == 12); end
    end
    step();
    n_checks++;
    if ({anim_done, frame_idx} !== 3'b010) begin n_fail++; $display("FAIL oneshot_end: got %b required 010", {anim_done, frame_idx}); end
    repeat (4) tick();
    n_checks++;
    if ({anim_done, frame_idx} !== 3'b010) begin n_fail++; $display("FAIL oneshot_idle: got %b required 010", {anim_done, frame_idx}); end
  endtask

  task test_boundaries;
    start(2'd3, 3'd0, 1'b1, 1'b0);
    repeat (4) tick();
    n_checks++;
    if (frame_idx !== 2'd3) begin n_fail++; $display("FAIL count_zero: got %0d required 3", frame_idx); end
    start(2'd3, 3'd2, 1'b1, 1'b0);
    repeat (4) tick();
    n_checks++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL wrap_fwd: got %0d required 0", frame_idx); end
    repeat (4) tick();
    n_checks++;
    if (frame_idx !== 2'd3) begin n_fail++; $display("FAIL wrap_back: got %0d required 3", frame_idx); end
  endtask

  task test_back_to_back;
    start(2'd0, 3'd3, 1'b1, 1'b0);
    repeat (3) tick();
    start(2'd2, 3'd3, 1'b1, 1'b1);
    n_checks++;
    if (frame_idx !== 2'd2) begin n_fail++; $display("FAIL coincident_first: got %0d required 2", frame_idx); end
    repeat (3) tick();
    n_checks++;
    if (frame_idx !== 2'd2) begin n_fail++; $display("FAIL coincident_hold: got %0d required 2", frame_idx); end
    tick();
    n_checks++;
    if (frame_idx !== 2'd3) begin n_fail++; $display("FAIL coincident_adv: got %0d required 3", frame_idx); end
    start(2'd0, 3'd1, 1'b0, 1'b0);
    repeat (3) tick();
    start(2'd1, 3'd1, 1'b0, 1'b0);
    n_checks++;
    if ({anim_done, frame_idx} !== 3'b001) begin n_fail++; $display("FAIL restart: got %b required 001", {anim_done, frame_idx}); end
    repeat (3) tick();
    n_checks++;
    if (anim_done !== 1'b0) begin n_fail++; $display("FAIL restart_early: got %b required 0", anim_done); end
    tick();
    n_checks++;
    if (anim_done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b required 1", anim_done); end
  endtask

  task test_mirror;
    logic [16:0] exp;
`ifdef SPRITE_FLIP_EN
    exp = 17'd104;
`else
    exp = 17'd0;
`endif
    start(2'd0, 3'd1, 1'b1, 1'b0);
    PosX = 100; PosY = 50; DrawX = 100; DrawY = 50; facing_left = 1'b1;
    step();
    n_checks++;
    if (rom_addr !== exp) begin n_fail++; $display("FAIL mirror_col: got %0d required %0d", rom_addr, exp); end
    facing_left = 1'b0;
  endtask

  task test_reset_mid;
    start(2'd1, 3'd2, 1'b1, 1'b0);
    PosX = 100; PosY = 50; DrawX = 204; DrawY = 51; blank = 1'b1; tb_idx = 5'd3;
    step(); step(); step();
    n_checks++;
    if (sprite_on !== 1'b1) begin n_fail++; $display("FAIL pre_reset_on: got %b required 1", sprite_on); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rom_addr, red, green, blue, sprite_on, anim_done, frame_idx} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got %h required 0", {rom_addr, red, green, blue, sprite_on, anim_done, frame_idx});
    end
    step();
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (sprite_on !== (k == 3)) begin n_fail++; $display("FAIL release_lat_%0d: got %b required %b", k, sprite_on, k == 3); end
    end
    repeat (4) tick();
    n_checks++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idle: got %0d required 0", frame_idx); end
  endtask

  initial begin
    test_reset();
    test_address();
    test_pixel();
    test_loop();
    test_oneshot();
    test_boundaries();
    test_back_to_back();
    test_mirror();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
